alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 138 +++++++++++++
 tb/tb_alu_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, iterative shifts and shift-add multiply,
// with a valid/ready handshake on both the request and the result side.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             C
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] CNT_ONE = (SW+1)'(1);
    localparam logic [SW:0] MUL_CNT = (SW+1)'(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state, state_n;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, acc_r;
    logic [SW:0]      cnt_r;

    logic             accept, load_res, res_c;
    logic [WIDTH-1:0] res, acc_nx, sh_nx;
    logic [WIDTH:0]   sum;
    logic [SW-1:0]    s_in;

    assign s_in   = Y[SW-1:0];
    assign sum    = {1'b0, X} + {1'b0, Y};
    assign acc_nx = b_r[0] ? acc_r + a_r : acc_r;
    assign sh_nx  = (op_r == OP_SHL) ? (a_r << 1) : (a_r >> 1);
    assign accept = in_ready && in_valid;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_res  = 1'b0;
        res       = '0;
        res_c     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_res = 1'b1;
                    state_n  = DONE;
                    case (op)
                        OP_ADD:  begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
                        OP_AND:  res = X & Y;
                        OP_NOT:  res = ~X;
                        OP_PASS: res = X;
                        OP_SUB:  begin res = X - Y; res_c = (X >= Y); end
                        OP_SHL, OP_SHR: begin
                            // A zero shift amount finishes immediately with the operand unchanged
                            res = X;
                            if (s_in != '0) begin
                                load_res = 1'b0;
                                state_n  = EXEC;
                            end
                        end
                        default: begin
                            load_res = 1'b0;
                            state_n  = EXEC;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (cnt_r == CNT_ONE) begin
                    load_res = 1'b1;
                    res      = (op_r == OP_MUL) ? acc_nx : sh_nx;
                    state_n  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Iteration registers: captured on accept, stepped once per EXEC cycle
    always_ff @(posedge Clk) begin
        if (accept) begin
            op_r  <= op;
            a_r   <= X;
            b_r   <= Y;
            acc_r <= '0;
            cnt_r <= (op == OP_MUL) ? MUL_CNT : {1'b0, s_in};
        end else if (state == EXEC) begin
            op_r  <= op_r;
            a_r   <= (op_r == OP_MUL) ? (a_r << 1) : sh_nx;
            b_r   <= b_r >> 1;
            acc_r <= acc_nx;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out <= '0;
            N   <= 1'b0;
            Z   <= 1'b0;
            P   <= 1'b0;
            C   <= 1'b0;
        end else if (load_res) begin
            out <= res;
            N   <= res[WIDTH-1];
            Z   <= (res == '0);
            P   <= !res[WIDTH-1] && (res != '0);
            C   <= res_c;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): directed corner cases, randomized ops against a
// behavioural model, backpressure, back-to-back requests and reset during a multiply.
module tb_alu_mc;
    localparam int WIDTH = 16;

    logic        Clk = 1'b0;
    logic        Reset, in_valid, in_ready, out_valid, out_ready, N, Z, P, C;
    logic [2:0]  op;
    logic [15:0] X, Y, out;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_exp;

    always #5 Clk = ~Clk;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .N(N), .Z(Z), .P(P), .C(C)
    );

    // Reference model: {C, result} from plain integer arithmetic
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua, ub, r;
        logic c;
        ua = a; ub = b; c = 1'b0;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 32'd65535); end
            3'd1: r = ua & ub;
            3'd2: r = ~ua;
            3'd3: r = ua;
            3'd4: begin r = ua - ub; c = (ua >= ub); end
            3'd5: r = ua << (ub % 16);
            3'd6: r = ua >> (ub % 16);
            default: r = ua * ub;
        endcase
        return {c, r[15:0]};
    endfunction

    // Cycles after the accepting edge until the result is presented
    function automatic int model_lat(input logic [2:0] o, input logic [15:0] b);
        if (o < 3'd5) return 0;
        if (o == 3'd7) return 16;
        return int'(b % 16);
    endfunction

    function automatic logic [3:0] model_nzpc(input logic [15:0] r, input logic c);
        logic n, z;
        n = r[15];
        z = (r == 16'h0);
        return {n, z, !n && !z, c};
    endfunction

    // Presents one request (DUT must be idle), then waits a bounded time for the result
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, output int lat);
        op = o; X = a; Y = b; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7)); X = 16'($urandom); Y = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; op = 3'd0; X = 16'h1; Y = 16'h1;
        repeat (2) @(posedge Clk);
        #1;
        in_valid = 1'b0; Reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out !== 16'h0 || {N, Z, P, C} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values: out=%h nzpc=%b, required 0000/0000", out, {N, Z, P, C});
        end
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [15:0] a, b, r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[11];
        int lat;
        v[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1000, 0};
        v[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 0};
        v[2]  = '{3'd4, 16'h0005, 16'h0005, 16'h0000, 4'b0101, 0};
        v[3]  = '{3'd4, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 0};
        v[4]  = '{3'd5, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 15};
        v[5]  = '{3'd6, 16'h8000, 16'h0010, 16'h8000, 4'b1000, 0};
        v[6]  = '{3'd7, 16'h0003, 16'hFFFF, 16'hFFFD, 4'b1000, 16};
        v[7]  = '{3'd7, 16'h0000, 16'h1234, 16'h0000, 4'b0100, 16};
        v[8]  = '{3'd1, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 0};
        v[9]  = '{3'd2, 16'h00FF, 16'h5555, 16'hFF00, 4'b1000, 0};
        v[10] = '{3'd3, 16'h1234, 16'hFFFF, 16'h1234, 4'b0010, 0};
        for (int i = 0; i < 11; i++) begin
            issue(v[i].o, v[i].a, v[i].b, lat);
            checks++;
            if (lat !== v[i].lat || out !== v[i].r || {N, Z, P, C} !== v[i].f) begin
                errors++;
                $display("FAIL directed[%0d]: lat=%0d out=%h nzpc=%b, required lat=%0d out=%h nzpc=%b",
                         i, lat, out, {N, Z, P, C}, v[i].lat, v[i].r, v[i].f);
            end
            last_exp = v[i].r;
            consume();
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [15:0] a, b;
        logic [16:0] e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
            if (i % 5 == 0) b = 16'($urandom_range(0, 3));
            e = model(o, a, b);
            issue(o, a, b, lat);
            checks++;
            if (out !== e[15:0]) begin
                errors++;
                $display("FAIL random_out op=%0d a=%h b=%h: got %h, required %h", o, a, b, out, e[15:0]);
            end
            checks++;
            if ({N, Z, P, C} !== model_nzpc(e[15:0], e[16])) begin
                errors++;
                $display("FAIL random_flags op=%0d: got %b, required %b", o, {N, Z, P, C}, model_nzpc(e[15:0], e[16]));
            end
            checks++;
            if (lat !== model_lat(o, b)) begin
                errors++;
                $display("FAIL random_latency op=%0d b=%h: got %0d, required %0d", o, b, lat, model_lat(o, b));
            end
            last_exp = e[15:0];
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(3'd0, 16'h1234, 16'h1111, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 3'd7; X = 16'($urandom); Y = 16'($urandom);
            @(posedge Clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 16'h2345 || {N, Z, P, C} !== 4'b0010) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b out=%h nzpc=%b, required 1/0/2345/0010",
                         i, out_valid, in_ready, out, {N, Z, P, C});
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 16'h2345) begin
            errors++;
            $display("FAIL idle_retain: valid=%b out=%h, required 0/2345", out_valid, out);
        end
        last_exp = 16'h2345;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [15:0] a, b;
        logic [16:0] e;
        int lat;
        o = 3'd0; a = 16'h0100; b = 16'h0011;
        issue(o, a, b, lat);
        for (int i = 0; i < 6; i++) begin
            o = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
            e = model(o, a, b);
            op = o; X = a; Y = b; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge Clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_no_same_cycle[%0d]: valid=%b ready=%b, required 0/1", i, out_valid, in_ready);
            end
            @(posedge Clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 64) begin
                @(posedge Clk); #1;
                lat++;
            end
            checks++;
            if (out !== e[15:0] || lat !== model_lat(o, b)) begin
                errors++;
                $display("FAIL b2b_result[%0d] op=%0d: out=%h lat=%0d, required %h/%0d",
                         i, o, out, lat, e[15:0], model_lat(o, b));
            end
            last_exp = e[15:0];
        end
        consume();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        op = 3'd7; X = 16'h1357; Y = 16'h2468; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== last_exp) begin
            errors++;
            $display("FAIL exec_retain: valid=%b ready=%b out=%h, required 0/0/%h", out_valid, in_ready, out, last_exp);
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0 || {N, Z, P, C} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_abort: valid=%b ready=%b out=%h nzpc=%b, required 0/1/0000/0000",
                     out_valid, in_ready, out, {N, Z, P, C});
        end
        issue(3'd0, 16'h0002, 16'h0003, lat);
        checks++;
        if (out !== 16'h0005 || {N, Z, P, C} !== 4'b0010 || lat !== 0) begin
            errors++;
            $display("FAIL post_reset_add: out=%h nzpc=%b lat=%0d, required 0005/0010/0", out, {N, Z, P, C}, lat);
        end
        consume();
    endtask

    initial begin
        last_exp = 16'h0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
